// File: rtl/decoder_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_pkg
// Description : Shared definitions for the decoder scan sequencer: scan state
//               enum, default widths and the next-unmasked-index helper.
//               The skip-mask feature (macro DECODER_SCAN_SKIP_EN) relies on
//               next_unmasked(); without it the mask is simply all zeros.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_scan_pkg;

    localparam int SEL_W_DEF = 3;
    localparam int DIV_W_DEF = 8;

    // Largest index width the helper below can serve. Masks are passed
    // zero-extended to this size so one function covers every SEL_W.
    localparam int MAX_SEL_W = 8;
    localparam int MASK_MAX  = 2 ** MAX_SEL_W;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } scan_state_e;

    // Returns the first index after 'cur' (in the given direction, modulo n)
    // whose mask bit is clear. The search covers n steps, so 'cur' itself is
    // the final candidate; an all-ones mask returns 'cur' unchanged.
    function automatic int next_unmasked(
        input int                  cur,
        input logic                down,
        input logic [MASK_MAX-1:0] mask,
        input int                  n
    );
        int   idx;
        int   res;
        logic found;
        res   = cur;
        found = 1'b0;
        for (int k = 1; k <= MASK_MAX; k++) begin
            if (!found && (k <= n)) begin
                idx = down ? ((cur + n - k) % n) : ((cur + k) % n);
                if (!mask[idx[MAX_SEL_W-1:0]]) begin
                    res   = idx;
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_ctrl_if
// Description : Control/status bundle between a host (master) and the scan
//               sequencer (slave).
//               master -> slave : start, stop, mode_down, one_shot, div,
//                                 skip_mask (only with DECODER_SCAN_SKIP_EN)
//               slave -> master : sel, sel_valid, busy, done
// Revision    : 1.0 - initial release
// ============================================================================
interface decoder_scan_ctrl_if
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) ();

    logic             start;
    logic             stop;
    logic             mode_down;
    logic             one_shot;
    logic [DIV_W-1:0] div;
`ifdef DECODER_SCAN_SKIP_EN
    logic [(2**SEL_W)-1:0] skip_mask;
`endif
    logic [SEL_W-1:0] sel;
    logic             sel_valid;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, mode_down, one_shot, div,
`ifdef DECODER_SCAN_SKIP_EN
        output skip_mask,
`endif
        input  sel, sel_valid, busy, done
    );

    modport slave (
        input  start, stop, mode_down, one_shot, div,
`ifdef DECODER_SCAN_SKIP_EN
        input  skip_mask,
`endif
        output sel, sel_valid, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/scan_dwell_counter.sv
`default_nettype none
// ============================================================================
// Module      : scan_dwell_counter
// Description : Dwell timer for the scan sequencer. clr_i zeroes the count and
//               captures limit_i; while en_i is high the count advances and
//               expire_o is high in the cycle the count equals the captured
//               limit, at which point the count wraps to zero.
// Ports       : clk, rst_n (async, active-low), clr_i, en_i,
//               limit_i[DIV_W], expire_o
// Revision    : 1.0 - initial release
// ============================================================================
module scan_dwell_counter
    import decoder_scan_pkg::*;
#(
    parameter int DIV_W = DIV_W_DEF
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    input  wire logic             clr_i,
    input  wire logic             en_i,
    input  wire logic [DIV_W-1:0] limit_i,
    output logic                  expire_o
);

    logic [DIV_W-1:0] cnt_q,   cnt_d;
    logic [DIV_W-1:0] limit_q, limit_d;
    logic             w_hit;

    // Combinational so the index steps at the end of the last dwell cycle;
    // div=0 therefore moves the index every cycle.
    assign w_hit    = en_i && (cnt_q == limit_q);
    assign expire_o = w_hit;

    always_comb begin
        cnt_d   = cnt_q;
        limit_d = limit_q;
        if (clr_i) begin
            cnt_d   = '0;
            limit_d = limit_i;
        end else if (en_i) begin
            cnt_d = w_hit ? '0 : (cnt_q + DIV_W'(1));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            limit_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            limit_q <= limit_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_ctrl
// Description : Drives the select input of a 2**SEL_W-output decoder, stepping
//               a registered index up or down at a dwell of div+1 cycles, in
//               continuous or one-shot mode with start/stop control.
//               Optional macro DECODER_SCAN_SKIP_EN adds skip_mask: masked
//               indices are never presented.
// Ports       : clk, rst_n (async, active-low), bus (decoder_scan_ctrl_if
//               slave: start, stop, mode_down, one_shot, div, [skip_mask],
//               sel, sel_valid, busy, done)
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_ctrl
    import decoder_scan_pkg::*;
#(
    parameter int SEL_W = SEL_W_DEF,
    parameter int DIV_W = DIV_W_DEF
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    decoder_scan_ctrl_if.slave   bus
);

    localparam int N = 2 ** SEL_W;

    scan_state_e       state_q, state_d;
    logic [SEL_W-1:0]  sel_q,   sel_d;
    logic              done_q,  done_d;
    logic              down_q;
    logic              one_shot_q;

    logic [N-1:0]        w_mask_live;
    logic [N-1:0]        w_mask_run;
    logic [MASK_MAX-1:0] w_mask_live_ext;
    logic [MASK_MAX-1:0] w_mask_run_ext;
    logic                w_all_masked;
    logic                w_launch;
    logic                w_running;
    logic                w_expire;
    logic [SEL_W-1:0]    w_first;
    logic [SEL_W-1:0]    w_next;
    logic [SEL_W-1:0]    w_last;

`ifdef DECODER_SCAN_SKIP_EN
    logic [N-1:0] mask_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q <= '0;
        end else if (w_launch) begin
            mask_q <= bus.skip_mask;
        end
    end

    assign w_mask_live = bus.skip_mask;
    assign w_mask_run  = mask_q;
`else
    assign w_mask_live = '0;
    assign w_mask_run  = '0;
`endif

    always_comb begin
        w_mask_live_ext        = '0;
        w_mask_run_ext         = '0;
        w_mask_live_ext[N-1:0] = w_mask_live;
        w_mask_run_ext[N-1:0]  = w_mask_run;
    end

    assign w_all_masked = &w_mask_live;
    assign w_running    = (state_q == ST_RUN);
    assign w_launch     = (state_q == ST_IDLE) && bus.start && !bus.stop && !w_all_masked;

    // First index is found by searching forward from the position just
    // "before" the start of the range; the last index is the first one found
    // when searching in the opposite direction from the range start.
    assign w_first = SEL_W'(next_unmasked(bus.mode_down ? 0 : N - 1, bus.mode_down,
                                          w_mask_live_ext, N));
    assign w_last  = SEL_W'(next_unmasked(down_q ? N - 1 : 0, !down_q,
                                          w_mask_run_ext, N));
    assign w_next  = SEL_W'(next_unmasked(int'(sel_q), down_q, w_mask_run_ext, N));

    scan_dwell_counter #(
        .DIV_W    (DIV_W)
    ) u_dwell (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (w_launch),
        .en_i     (w_running),
        .limit_i  (bus.div),
        .expire_o (w_expire)
    );

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (w_launch) begin
                    state_d = ST_RUN;
                    sel_d   = w_first;
                end
            end
            ST_RUN: begin
                // stop takes priority, including over one-shot completion,
                // so an aborted pass never reports done.
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    sel_d   = '0;
                end else if (w_expire) begin
                    if (one_shot_q && (sel_q == w_last)) begin
                        state_d = ST_IDLE;
                        sel_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        sel_d = w_next;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                sel_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            done_q     <= 1'b0;
            down_q     <= 1'b0;
            one_shot_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
            if (w_launch) begin
                down_q     <= bus.mode_down;
                one_shot_q <= bus.one_shot;
            end
        end
    end

    assign bus.sel       = sel_q;
    assign bus.sel_valid = w_running;
    assign bus.busy      = w_running;
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_decoder_scan_ctrl
// Description : Self-checking bench for decoder_scan_ctrl. Expected indices
//               come from an ordered list of presented indices, each held
//               div+1 cycles. Skip-mask steps run only with
//               DECODER_SCAN_SKIP_EN defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decoder_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] tb_mask;
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    decoder_scan_ctrl_if #(.SEL_W(3), .DIV_W(8)) bus ();

`ifdef DECODER_SCAN_SKIP_EN
    assign bus.skip_mask = tb_mask;
`endif

    decoder_scan_ctrl #(
        .SEL_W (3),
        .DIV_W (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(bus.sel_valid), 32'd0);
        chk({tag, "_busy"},  32'(bus.busy),      32'd0);
        chk({tag, "_done"},  32'(bus.done),      32'd0);
        chk({tag, "_sel"},   32'(bus.sel),       32'd0);
    endtask

    // One scan from start pulse to idle. stop_t < 0 means no stop request.
    task automatic run_scan(input int dv, input bit dn, input bit os,
                            input logic [7:0] msk, input int stop_t, input bit perturb);
        int         order[$];
        int         i;
        int         len;
        int         per;
        int         t;
        int         exp_sel;
        bit         fin;
        logic [7:0] y;
        for (int k = 0; k < 8; k++) begin
            i = dn ? 7 - k : k;
            if (!msk[i[2:0]]) order.push_back(i);
        end
        len = order.size();
        per = dv + 1;

        bus.div       = dv[7:0];
        bus.mode_down = dn;
        bus.one_shot  = os;
        tb_mask       = msk;
        bus.stop      = 1'b0;
        bus.start     = 1'b1;

        if (len == 0) begin
            @(negedge clk);
            bus.start = 1'b0;
            check_idle("allmask");
            @(negedge clk);
            check_idle("allmask2");
            return;
        end

        t   = 0;
        fin = 1'b0;
        while (!fin) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (os && (t == len * per)) begin
                chk("done_pulse", 32'(bus.done),      32'd1);
                chk("done_valid", 32'(bus.sel_valid), 32'd0);
                chk("done_busy",  32'(bus.busy),      32'd0);
                chk("done_sel",   32'(bus.sel),       32'd0);
                fin = 1'b1;
            end else if (t > 2000) begin
                chk("scan_timeout", 32'(t), 32'd0);
                fin = 1'b1;
            end else begin
                exp_sel = order[(t / per) % len];
                for (int j = 0; j < 8; j++) y[j] = (32'(bus.sel) == j);
                chk("sel",      32'(bus.sel),       32'(exp_sel));
                chk("decode_y", 32'(y),             32'd1 << exp_sel);
                chk("valid",    32'(bus.sel_valid), 32'd1);
                chk("busy",     32'(bus.busy),      32'd1);
                chk("no_done",  32'(bus.done),      32'd0);
                if (t == stop_t) begin
                    bus.stop = 1'b1;
                    @(negedge clk);
                    bus.stop = 1'b0;
                    check_idle("stopped");
                    fin = 1'b1;
                end else if (perturb) begin
                    bus.div       = 8'($urandom);
                    bus.mode_down = 1'($urandom_range(0, 1));
                    bus.one_shot  = 1'($urandom_range(0, 1));
                    bus.start     = 1'($urandom_range(0, 1));
                    tb_mask       = 8'($urandom);
                end
            end
            t++;
        end
        @(negedge clk);
        check_idle("post");
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.mode_down = 1'b0;
        bus.one_shot  = 1'b0;
        bus.div       = 8'd0;
        tb_mask       = 8'd0;

        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("after_reset");

        // div=2 ascending one-shot: 24 valid cycles then done
        run_scan(2, 1'b0, 1'b1, 8'h00, -1, 1'b0);
        // div=0 descending continuous, stop in the tenth valid cycle
        run_scan(0, 1'b1, 1'b0, 8'h00, 9, 1'b0);

        // start and stop together in IDLE: stop wins
        bus.start = 1'b1;
        bus.stop  = 1'b1;
        @(negedge clk);
        check_idle("start_stop");
        @(negedge clk);
        check_idle("start_stop2");
        bus.start = 1'b0;
        bus.stop  = 1'b0;

        // mid-run start pulses and div/mode changes must be ignored
        run_scan(3, 1'b0, 1'b0, 8'h00, 37, 1'b1);
        run_scan(1, 1'b1, 1'b1, 8'h00, -1, 1'b1);
        // stop coincides with one-shot completion: no done
        run_scan(1, 1'b0, 1'b1, 8'h00, 15, 1'b0);

        // asynchronous reset while sel=5
        bus.div       = 8'd0;
        bus.mode_down = 1'b0;
        bus.one_shot  = 1'b0;
        bus.start     = 1'b1;
        for (int t = 0; t <= 5; t++) begin
            @(negedge clk);
            bus.start = 1'b0;
            chk("pre_reset_sel", 32'(bus.sel), 32'(t));
        end
        #2 rst_n = 1'b0;
        #1 check_idle("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle("reset_release");
        end

`ifdef DECODER_SCAN_SKIP_EN
        run_scan(1, 1'b0, 1'b1, 8'hA5, -1, 1'b0);
        run_scan(0, 1'b0, 1'b1, 8'hFF, -1, 1'b0);
        run_scan(2, 1'b1, 1'b0, 8'h3C, 20, 1'b1);
`endif

        // randomized scans
        for (int r = 0; r < 10; r++) begin
            int         rdv;
            bit         rdn;
            bit         ros;
            int         rstop;
            logic [7:0] rmask;
            rdv = $urandom_range(0, 4);
            rdn = 1'($urandom_range(0, 1));
            ros = 1'($urandom_range(0, 1));
`ifdef DECODER_SCAN_SKIP_EN
            rmask = 8'($urandom);
`else
            rmask = 8'h00;
`endif
            if (!ros || ($urandom_range(0, 2) == 0)) rstop = $urandom_range(0, 40);
            else rstop = -1;
            run_scan(rdv, rdn, ros, rmask, rstop, 1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
